rotor_stage: RTL
================

// Module: rotor_stage
// PURPOSE
//  One Enigma rotor in the character path. Upstream is the plugboard or the previous rotor; downstream is the next rotor or the reflector.
//  Maps a char forward through its wiring at the current position, hands it downstream (valid/din), waits for done/dout, maps it back inversely and returns it upstream.
//  Steps its position per keypress and emits a carry at its notch.
// PARAMETERS
//  ALPHA      26  letters in the alphabet
//  ASCII_A    65  code of 'A'
// PORTS
//  clk        in   1    clock, all logic on rising edge
//  reset_n    in   1    synchronous active-low reset
//  set        in   1    load wiring/position/notch (honoured in IDLE only)
//  idx_in     in   208  wiring: 26 ASCII bytes, entry for 'A' at [207:200], 'Z' at [7:0]
//  pos_in     in   5    initial position 0..25 (>=26 loads 0)
//  notch_in   in   5    position at which stepping emits carry
//  valid      in   1    upstream char strobe (1 cycle)
//  din        in   8    upstream ASCII char
//  step_in    in   1    step this rotor for this char (sampled with valid)
//  dout       out  8    returned char to upstream
//  done       out  1    1-cycle strobe, dout valid
//  step_out   out  1    1-cycle carry pulse to next rotor
//  fwd_valid  out  1    1-cycle strobe to downstream
//  fwd_dout   out  8    forward-mapped char to downstream
//  ref_done   in   1    downstream completion strobe
//  ref_din    in   8    downstream returned char (valid with ref_done)
//  busy       out  1    high outside IDLE
// BEHAVIOUR
//  - Reset (reset_n==0 at edge): state IDLE, pos=0, wiring=0, notch=0; dout, fwd_dout=8'h00; done, fwd_valid, step_out, busy=0. A reset mid-transaction drops the char; no done is issued.
//  - Offset o = pos (minus ring when RING_SETTING_EN). All arithmetic is mod 26 on c=char-65.
//  - Forward: k=(c+o)%26; out=((W[k]-65)-o)%26 + 65.
//  - Inverse: t=(c+o)%26; j = the unique index with W[j]==t+65; out=(j-o)%26 + 65. If no match (bad wiring), out=din.
//  - FSM, all outputs registered:
//    IDLE: set -> load regs. valid with din in 'A'..'Z' -> FWD.
//          valid with a non-letter -> BYP.
//          set and valid in the same cycle: set is applied and valid is ignored.
//    FWD (1 cyc): if step_in was 1, pos'=(pos+1)%26 and the forward map uses pos'.
//          step_out=1 for this cycle iff the old pos==notch.
//          fwd_valid=1, fwd_dout=forward(din) -> WAIT.
//    WAIT: hold until ref_done; capture ref_din -> BWD. Upstream valid is ignored while busy.
//    BWD (1 cyc): done=1, dout=inverse(captured) -> IDLE.
//    BYP (1 cyc): done=1, dout=din; no step, no fwd_valid -> IDLE.
//  - Latency: valid@0 -> fwd_valid@1 -> (reflector done@2 min) -> done@3. Bypass: done@1.
//  - Wrap: pos 25 steps to 0. step_in=0 leaves pos unchanged and step_out=0.
//  - done, fwd_valid and step_out are never high for more than 1 cycle. dout returns to 0 when done is low.
// CONFIGURATION
//  RING_SETTING_EN defined: adds port ring_in [4:0] (Ringstellung), loaded on set; offset o=(pos-ring)%26.
//  Not defined: no ring_in port; ring is fixed at 0; o=pos.
// STRUCTURE
//  Package enigma_pkg: ALPHA, ASCII_A, state encoding (IDLE/FWD/WAIT/BWD/BYP), mod26 add/sub functions.
//  Sub-module rotor_map: combinational forward/inverse lookup (wiring, char, offset, dir) -> char. The FSM stays in rotor_stage.
// TESTING (bench models the downstream reflector: done 1 cycle after fwd_valid)
//  1. Wiring "ABC..Z" (identity), pos 0, step_in=0, din 'G' -> fwd_dout 'G'.
//     Reflector returns 'T' -> dout 'T', done at cycle 3.
//  2. Rotor I "EKMFLGDQVZNTOWYHXUSPAIBRCJ", pos 0, step_in=1, din 'A' -> pos=1, fwd_dout 'J'.
//     Reflector B returns 'X' -> dout 'N'.
//  3. Rotor I, pos_in=16, notch=16, step_in=1 -> step_out 1-cycle pulse, pos=17.
//     Same test with pos_in=25, notch=16 -> pos=0, no step_out.
//  4. din 8'h20 -> done at cycle 1, dout 8'h20, no fwd_valid, pos unchanged.
//  5. valid during WAIT is ignored (one done only). reset_n low in WAIT -> IDLE, all outputs 0, no done.
//  6. RING_SETTING_EN: rotor I, pos 0, ring 1, step_in=0, din 'A' -> fwd_dout 'K'.

Source files
------------

// File: rtl/enigma_pkg.sv
// enigma_pkg: shared constants, FSM state encoding and mod-26 helpers
// for the Enigma rotor datapath. Optional feature macro used by the
// rotor files: RING_SETTING_EN (adds the Ringstellung input).
package enigma_pkg;

  localparam int         ALPHA    = 26;        // letters in the alphabet
  localparam logic [7:0] ASCII_A  = 8'd65;     // code of 'A'
  localparam int         WIRING_W = ALPHA * 8; // packed wiring table width

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FWD  = 3'd1,
    WAIT = 3'd2,
    BWD  = 3'd3,
    BYP  = 3'd4
  } state_t;

  // (a + b) mod 26 for operands already in 0..25
  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'(ALPHA)) s = s - 6'(ALPHA);
    return s[4:0];
  endfunction

  // (a - b) mod 26 for operands already in 0..25
  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    if (a >= b) s = {1'b0, a} - {1'b0, b};
    else        s = {1'b0, a} + 6'(ALPHA) - {1'b0, b};
    return s[4:0];
  endfunction

  // Reduce an arbitrary byte to 0..25
  function automatic logic [4:0] mod26_byte(input logic [7:0] v);
    return 5'(v % 8'(ALPHA));
  endfunction

  // Letter index (0..25) back to its ASCII code
  function automatic logic [7:0] to_ascii(input logic [4:0] i);
    return {3'b000, i} + ASCII_A;
  endfunction

  // True for 'A'..'Z'
  function automatic logic is_letter(input logic [7:0] ch);
    return (ch >= ASCII_A) && (ch < ASCII_A + 8'(ALPHA));
  endfunction

  // Out-of-range positions / ring settings load as 0
  function automatic logic [4:0] clamp_pos(input logic [4:0] p);
    return (p >= 5'(ALPHA)) ? 5'd0 : p;
  endfunction

endpackage

// File: rtl/rotor_stage_if.sv
// rotor_stage_if: configuration, upstream and downstream signals of one
// rotor stage. master = the environment driving the rotor (plugboard /
// previous rotor / reflector side); slave = the rotor itself.
// RING_SETTING_EN adds ring_in.
interface rotor_stage_if;
  import enigma_pkg::*;

  // configuration
  logic                set;
  logic [WIRING_W-1:0] idx_in;
  logic [4:0]          pos_in;
  logic [4:0]          notch_in;
`ifdef RING_SETTING_EN
  logic [4:0]          ring_in;
`endif

  // upstream side
  logic                valid;
  logic [7:0]          din;
  logic                step_in;
  logic [7:0]          dout;
  logic                done;
  logic                busy;

  // carry to the next rotor
  logic                step_out;

  // downstream side
  logic                fwd_valid;
  logic [7:0]          fwd_dout;
  logic                ref_done;
  logic [7:0]          ref_din;

`ifdef RING_SETTING_EN
  modport master (
    output set, idx_in, pos_in, notch_in, ring_in,
    output valid, din, step_in, ref_done, ref_din,
    input  dout, done, busy, step_out, fwd_valid, fwd_dout
  );
  modport slave (
    input  set, idx_in, pos_in, notch_in, ring_in,
    input  valid, din, step_in, ref_done, ref_din,
    output dout, done, busy, step_out, fwd_valid, fwd_dout
  );
`else
  modport master (
    output set, idx_in, pos_in, notch_in,
    output valid, din, step_in, ref_done, ref_din,
    input  dout, done, busy, step_out, fwd_valid, fwd_dout
  );
  modport slave (
    input  set, idx_in, pos_in, notch_in,
    input  valid, din, step_in, ref_done, ref_din,
    output dout, done, busy, step_out, fwd_valid, fwd_dout
  );
`endif

endinterface

// File: rtl/rotor_map.sv
// rotor_map: combinational rotor lookup. dir_i=0 maps a letter forward
// through the wiring at the given offset; dir_i=1 maps it back through the
// inverse wiring. A missing inverse entry (bad wiring) returns the input.
module rotor_map
  import enigma_pkg::*;
(
  input  logic [WIRING_W-1:0] wiring_i,
  input  logic [7:0]          char_i,
  input  logic [4:0]          offset_i,
  input  logic                dir_i,
  output logic [7:0]          char_o
);

  logic [7:0] w_arr [ALPHA];   // w_arr[0] is the entry for 'A'
  logic [ALPHA-1:0] match;
  logic [4:0] c_idx;           // incoming char as 0..25
  logic [4:0] k_idx;           // contact index seen by the wiring
  logic [7:0] fwd_char;
  logic [7:0] inv_target;
  logic [7:0] inv_char;
  logic       inv_found;
  logic [4:0] inv_idx;

  // Unpack the wiring table (entry for 'A' sits in the top byte) and flag
  // every contact whose output letter equals the inverse search target.
  generate
    for (genvar gi = 0; gi < ALPHA; gi++) begin : g_contact
      assign w_arr[gi] = wiring_i[(ALPHA-1-gi)*8 +: 8];
      assign match[gi] = (w_arr[gi] == inv_target);
    end
  endgenerate

  assign c_idx = mod26_byte(char_i - ASCII_A);
  assign k_idx = add26(c_idx, offset_i);

  // Forward: rotate in, pass through the wiring, rotate back out.
  assign fwd_char   = to_ascii(sub26(mod26_byte(w_arr[k_idx] - ASCII_A), offset_i));
  assign inv_target = to_ascii(k_idx);

  // Inverse: pick the contact that produces the target letter (lowest index
  // wins should the wiring ever contain duplicates).
  always_comb begin
    inv_found = 1'b0;
    inv_idx   = 5'd0;
    for (int i = ALPHA - 1; i >= 0; i--) begin
      if (match[i]) begin
        inv_found = 1'b1;
        inv_idx   = 5'(i);
      end
    end
  end

  assign inv_char = inv_found ? to_ascii(sub26(inv_idx, offset_i)) : char_i;
  assign char_o   = dir_i ? inv_char : fwd_char;

endmodule

// File: rtl/rotor_stage.sv
// rotor_stage: one Enigma rotor in the character path. A letter from
// upstream is mapped forward and handed downstream, the downstream reply is
// mapped back inversely and returned upstream. Non-letters bypass the rotor.
// The rotor steps per keypress (step_in) and pulses step_out at its notch.
// Optional feature macro: RING_SETTING_EN (ring_in, offset = pos - ring).
module rotor_stage
  import enigma_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  rotor_stage_if.slave bus
);

  state_t              state_q, state_d;
  logic [4:0]          pos_q, pos_d;
  logic [WIRING_W-1:0] wiring_q, wiring_d;
  logic [4:0]          notch_q, notch_d;
  logic [4:0]          ring_cur;

  logic [7:0]          dout_q, dout_d;
  logic                done_q, done_d;
  logic                fwd_valid_q, fwd_valid_d;
  logic [7:0]          fwd_dout_q, fwd_dout_d;
  logic                step_out_q, step_out_d;

`ifdef RING_SETTING_EN
  logic [4:0]          ring_q, ring_d;
  assign ring_cur = ring_q;
`else
  assign ring_cur = 5'd0;
`endif

  logic [4:0] pos_stepped;   // position the forward map must use
  logic [4:0] fwd_off;
  logic [4:0] inv_off;
  logic       map_dir;
  logic [7:0] map_char_in;
  logic [4:0] map_off;
  logic [7:0] map_char_out;

  // Stepping happens before the forward lookup of the same keypress.
  assign pos_stepped = bus.step_in ? add26(pos_q, 5'd1) : pos_q;
  assign fwd_off     = sub26(pos_stepped, ring_cur);
  assign inv_off     = sub26(pos_q, ring_cur);

  // One lookup unit is shared: forward while idle, inverse while waiting
  // for the downstream reply.
  assign map_dir     = (state_q == WAIT);
  assign map_char_in = map_dir ? bus.ref_din : bus.din;
  assign map_off     = map_dir ? inv_off : fwd_off;

  rotor_map u_map (
    .wiring_i (wiring_q),
    .char_i   (map_char_in),
    .offset_i (map_off),
    .dir_i    (map_dir),
    .char_o   (map_char_out)
  );

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    wiring_d    = wiring_q;
    notch_d     = notch_q;
`ifdef RING_SETTING_EN
    ring_d      = ring_q;
`endif
    dout_d      = 8'h00;
    done_d      = 1'b0;
    fwd_valid_d = 1'b0;
    fwd_dout_d  = 8'h00;
    step_out_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.set) begin
          // configuration load wins over a coincident keypress
          wiring_d = bus.idx_in;
          pos_d    = clamp_pos(bus.pos_in);
          notch_d  = bus.notch_in;
`ifdef RING_SETTING_EN
          ring_d   = clamp_pos(bus.ring_in);
`endif
        end else if (bus.valid) begin
          if (is_letter(bus.din)) begin
            state_d     = FWD;
            pos_d       = pos_stepped;
            step_out_d  = bus.step_in && (pos_q == notch_q);
            fwd_valid_d = 1'b1;
            fwd_dout_d  = map_char_out;
          end else begin
            state_d = BYP;
            done_d  = 1'b1;
            dout_d  = bus.din;
          end
        end
      end
      FWD: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.ref_done) begin
          state_d = BWD;
          done_d  = 1'b1;
          dout_d  = map_char_out;
        end
      end
      BWD, BYP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, configuration and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pos_q       <= 5'd0;
      wiring_q    <= '0;
      notch_q     <= 5'd0;
`ifdef RING_SETTING_EN
      ring_q      <= 5'd0;
`endif
      dout_q      <= 8'h00;
      done_q      <= 1'b0;
      fwd_valid_q <= 1'b0;
      fwd_dout_q  <= 8'h00;
      step_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      wiring_q    <= wiring_d;
      notch_q     <= notch_d;
`ifdef RING_SETTING_EN
      ring_q      <= ring_d;
`endif
      dout_q      <= dout_d;
      done_q      <= done_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_dout_q  <= fwd_dout_d;
      step_out_q  <= step_out_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.done      = done_q;
  assign bus.fwd_valid = fwd_valid_q;
  assign bus.fwd_dout  = fwd_dout_q;
  assign bus.step_out  = step_out_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
